// File: rtl/heapsort_pkg.sv
// rtl/heapsort_pkg.sv - shared constants, state enum and key-vector type for the heap-sort stream adapter
package heapsort_pkg;

  localparam int N_ELEM    = 10;
  localparam int W_KEY     = 16;
  localparam int W_WORD    = N_ELEM * W_KEY + 1;
  localparam int START_BIT = W_WORD - 1;
  localparam int DONE_BIT  = W_WORD - 1;
  localparam int W_IDX     = 4;

  typedef logic [N_ELEM*W_KEY-1:0] key_vec_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  // Read mux over a packed key vector; indices past the last key read as zero.
  function automatic logic [W_KEY-1:0] key_at(input key_vec_t v, input logic [W_IDX-1:0] idx);
    logic [W_KEY-1:0] r;
    r = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      if (idx == W_IDX'(k)) r = v[k*W_KEY +: W_KEY];
    end
    return r;
  endfunction

endpackage

// File: rtl/heapsort_block_buf.sv
// rtl/heapsort_block_buf.sv - 10x16 key register file with indexed write and whole-block load
module heapsort_block_buf
  import heapsort_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [W_IDX-1:0] wr_idx,
  input  logic [W_KEY-1:0] wr_data,
  input  logic             ld_en,
  input  key_vec_t         ld_vec,
  output key_vec_t         vec
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec <= '0;
    end else if (ld_en) begin
      vec <= ld_vec;
    end else if (wr_en) begin
      for (int k = 0; k < N_ELEM; k++) begin
        if (wr_idx == W_IDX'(k)) vec[k*W_KEY +: W_KEY] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/heapsort_stream_adapter.sv
// rtl/heapsort_stream_adapter.sv - fills a 10-key block from a stream, runs the heap-sort core, replays the sorted block
module heapsort_stream_adapter
  import heapsort_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
)
(
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic [W_KEY-1:0]  s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [W_KEY-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [W_WORD-1:0] sort_word,
  input  logic [W_WORD-1:0] sort_result,
  output logic              timeout_err
);

  localparam int               W_CNT     = $clog2(TIMEOUT_CYCLES);
  localparam logic [W_IDX-1:0] LAST_IDX  = W_IDX'(N_ELEM - 1);
  localparam logic [W_CNT-1:0] CNT_LIMIT = W_CNT'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [W_IDX-1:0] fill_idx;
  logic [W_IDX-1:0] drain_idx;
  logic [W_IDX-1:0] drain_nxt;
  logic [W_CNT-1:0] cnt;
  key_vec_t         hold_vec;
  key_vec_t         drain_vec;
  key_vec_t         issue_vec;
  logic             hold_we;
  logic             drain_ld;
  logic             done;

  assign done      = sort_result[DONE_BIT];
  assign hold_we   = (state == ST_FILL) && s_valid && s_ready;
  assign drain_ld  = (state == ST_WAIT) && done;
  assign drain_nxt = drain_idx + W_IDX'(1);

  // The final key is still in flight on s_data when the block is packed.
  always_comb begin
    issue_vec = hold_vec;
    issue_vec[(N_ELEM-1)*W_KEY +: W_KEY] = s_data;
  end

  heapsort_block_buf u_hold (
    .clk     (system1000),
    .rst_n   (system1000_rstn),
    .wr_en   (hold_we),
    .wr_idx  (fill_idx),
    .wr_data (s_data),
    .ld_en   (1'b0),
    .ld_vec  ('0),
    .vec     (hold_vec)
  );

  heapsort_block_buf u_drain (
    .clk     (system1000),
    .rst_n   (system1000_rstn),
    .wr_en   (1'b0),
    .wr_idx  ('0),
    .wr_data ('0),
    .ld_en   (drain_ld),
    .ld_vec  (sort_result[N_ELEM*W_KEY-1:0]),
    .vec     (drain_vec)
  );

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state       <= ST_FILL;
      fill_idx    <= '0;
      drain_idx   <= '0;
      cnt         <= '0;
      sort_word   <= '0;
      s_ready     <= 1'b1;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_FILL: begin
          if (s_valid && s_ready) begin
            if (fill_idx == LAST_IDX) begin
              fill_idx  <= '0;
              s_ready   <= 1'b0;
              sort_word <= {1'b1, issue_vec};
              state     <= ST_ISSUE;
            end else begin
              fill_idx <= fill_idx + W_IDX'(1);
            end
          end
        end
        ST_ISSUE: begin
          sort_word[START_BIT] <= 1'b0;
          cnt                  <= '0;
          state                <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done is checked first so a result arriving on the limit cycle is kept.
          if (done) begin
            cnt       <= '0;
            drain_idx <= '0;
            m_valid   <= 1'b1;
            m_data    <= sort_result[W_KEY-1:0];
            m_last    <= 1'b0;
            state     <= ST_DRAIN;
          end else if (cnt == CNT_LIMIT) begin
            cnt         <= '0;
            timeout_err <= 1'b1;
            fill_idx    <= '0;
            s_ready     <= 1'b1;
            state       <= ST_FILL;
          end else begin
            cnt <= cnt + W_CNT'(1);
          end
        end
        ST_DRAIN: begin
          if (m_valid && m_ready) begin
            if (drain_idx == LAST_IDX) begin
              drain_idx <= '0;
              m_valid   <= 1'b0;
              m_last    <= 1'b0;
              s_ready   <= 1'b1;
              state     <= ST_FILL;
            end else begin
              drain_idx <= drain_nxt;
              m_data    <= key_at(drain_vec, drain_nxt);
              m_last    <= (drain_nxt == LAST_IDX);
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_heapsort_stream_adapter.sv
// tb/tb_heapsort_stream_adapter.sv - directed table-driven bench for heapsort_stream_adapter
module tb_heapsort_stream_adapter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [15:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic [160:0] sort_word;
  logic [160:0] sort_result = '0;
  logic         timeout_err;

  always #5 clk = ~clk;

  heapsort_stream_adapter dut (
    .system1000      (clk),
    .system1000_rstn (rst_n),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_last          (m_last),
    .sort_word       (sort_word),
    .sort_result     (sort_result),
    .timeout_err     (timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;

  int           model_delay = 20;
  bit           model_never = 1'b0;
  bit           force_done  = 1'b0;
  int           m_cnt       = 0;
  logic [159:0] m_sorted    = '0;

  int           cyc = 0, n_start = 0, start_cyc = 0, n_to = 0, to_cyc = 0, n_mv = 0;
  logic [160:0] start_word = '0;

  function automatic logic [159:0] sort10(input logic [159:0] v);
    logic [15:0] a[10];
    logic [15:0] t;
    logic [159:0] r;
    for (int i = 0; i < 10; i++) a[i] = v[i*16 +: 16];
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 9 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < 10; i++) r[i*16 +: 16] = a[i];
    return r;
  endfunction

  function automatic logic [159:0] pk(input int a0, input int a1, input int a2, input int a3, input int a4,
                                      input int a5, input int a6, input int a7, input int a8, input int a9);
    return {16'(a9), 16'(a8), 16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  // Behavioural sorter plus event monitor, all sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sort_word[160]) begin
      n_start    <= n_start + 1;
      start_word <= sort_word;
      start_cyc  <= cyc;
      m_sorted   <= sort10(sort_word[159:0]);
      m_cnt      <= model_delay;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
    if (timeout_err) begin
      n_to   <= n_to + 1;
      to_cyc <= cyc;
    end
    if (m_valid) n_mv <= n_mv + 1;
    if (m_cnt == 1 && !sort_word[160] && !model_never)
      sort_result <= {1'b1, m_sorted};
    else
      sort_result <= {force_done, 160'h0};
  end

  task automatic check(input string name, input logic [160:0] act, input logic [160:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_keys(input logic [159:0] keys, input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      s_data  = keys[k*16 +: 16];
      s_valid = 1'b1;
      w = 0;
      while (!s_ready && w < 3000) begin tick(); w++; end
      if (w >= 3000) check("s_ready_wait", 161'(s_ready), 161'd1);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic collect(input string name, input bit stall, input logic [159:0] exp);
    logic [159:0] got;
    logic [9:0]   lastm;
    logic [16:0]  prev;
    bit           prev_stall, unstable;
    int           k, w;
    got = '0; lastm = '0; prev = '0; prev_stall = 1'b0; unstable = 1'b0; k = 0; w = 0;
    while (k < 10 && w < 3000) begin
      m_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (m_valid && prev_stall && {m_last, m_data} !== prev) unstable = 1'b1;
      if (m_valid && m_ready) begin
        got[k*16 +: 16] = m_data;
        lastm[k]        = m_last;
        k++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = m_valid;
        prev       = {m_last, m_data};
      end
      tick();
      w++;
    end
    m_ready = 1'b0;
    check({name, "_count"}, 161'(k), 161'd10);
    check({name, "_data"}, 161'(got), 161'(exp));
    check({name, "_last"}, 161'(lastm), 161'(10'h200));
    check({name, "_idle"}, 161'({m_valid, s_ready}), 161'(2'b01));
    if (stall) check({name, "_stable"}, 161'(unstable), 161'd0);
  endtask

  typedef struct {
    logic [159:0] keys;
    logic [159:0] exp;
    int           delay;
    bit           stall;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    s0, t0, mv0, w;
    string nm;

    tbl[0] = '{pk(9, 3, 7, 1, 0, 8, 2, 6, 5, 4), pk(0, 1, 2, 3, 4, 5, 6, 7, 8, 9), 20, 1'b0};
    tbl[1] = '{pk(9, 3, 7, 1, 0, 8, 2, 6, 5, 4), pk(0, 1, 2, 3, 4, 5, 6, 7, 8, 9), 20, 1'b1};
    tbl[2] = '{pk('hFFFF, 0, 'hFFFF, 0, 'hFFFF, 0, 'hFFFF, 0, 'hFFFF, 0),
               pk(0, 0, 0, 0, 0, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF), 20, 1'b0};
    tbl[3] = '{pk(500, 20, 20, 7, 65534, 1, 300, 1, 0, 42),
               pk(0, 1, 1, 7, 20, 20, 42, 300, 500, 65534), 1, 1'b0};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) tick();
    check("rst_sort_word", sort_word, 161'd0);
    check("rst_flags", 161'({s_ready, m_valid, m_last, timeout_err}), 161'(4'b1000));
    check("rst_m_data", 161'(m_data), 161'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      nm = $sformatf("v%0d", i);
      model_delay = tbl[i].delay;
      s0 = n_start; t0 = n_to;
      send_keys(tbl[i].keys, 10);
      collect(nm, tbl[i].stall, tbl[i].exp);
      check({nm, "_starts"}, 161'(n_start - s0), 161'd1);
      check({nm, "_word"}, start_word, {1'b1, tbl[i].keys});
      check({nm, "_timeouts"}, 161'(n_to - t0), 161'd0);
    end

    // Sorter never answers: block abandoned, then a normal block follows.
    model_delay = 20; model_never = 1'b1;
    t0 = n_to; mv0 = n_mv;
    send_keys(tbl[0].keys, 10);
    w = 0;
    while (n_to == t0 && w < 1500) begin tick(); w++; end
    repeat (5) tick();
    check("to_pulses", 161'(n_to - t0), 161'd1);
    check("to_delay", 161'((to_cyc - start_cyc) inside {1024, 1025}), 161'd1);
    check("to_no_mvalid", 161'(n_mv - mv0), 161'd0);
    check("to_s_ready", 161'(s_ready), 161'd1);
    model_never = 1'b0;
    send_keys(tbl[0].keys, 10);
    collect("after_to", 1'b0, tbl[0].exp);

    // Reset mid-fill discards the partial block.
    send_keys(pk(11, 12, 13, 14, 15, 16, 17, 18, 19, 20), 5);
    s0 = n_start;
    rst_n = 1'b0;
    tick(); tick();
    check("rst_mid_outs", {m_valid, s_ready, sort_word[158:0]}, {1'b0, 1'b1, 159'h0});
    rst_n = 1'b1;
    tick();
    mv0 = n_mv;
    send_keys(pk(30, 25, 40, 5, 35, 10, 45, 15, 50, 20), 10);
    collect("rst_fresh", 1'b0, pk(5, 10, 15, 20, 25, 30, 35, 40, 45, 50));
    check("rst_fresh_starts", 161'(n_start - s0), 161'd1);
    check("rst_fresh_word", start_word, {1'b1, pk(30, 25, 40, 5, 35, 10, 45, 15, 50, 20)});
    check("rst_fresh_mvalid_cycles", 161'(n_mv - mv0), 161'd10);

    // Spurious done while filling must be ignored.
    force_done = 1'b1;
    repeat (3) tick();
    force_done = 1'b0;
    repeat (2) tick();
    check("spur_fill", 161'({m_valid, s_ready}), 161'(2'b01));
    send_keys(tbl[2].keys, 10);
    collect("spur_after", 1'b0, tbl[2].exp);

    // Done lands on the timeout-limit cycle: done wins.
    model_delay = 1024;
    t0 = n_to;
    send_keys(tbl[0].keys, 10);
    collect("coinc", 1'b0, tbl[0].exp);
    check("coinc_timeouts", 161'(n_to - t0), 161'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
